// File: rtl/uart_tx_if.sv
// uart_tx_if: byte valid/ready handshake into the UART transmitter.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a one-byte holding register in front of the shifter.
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop (11-bit frame).
module uart_tx #(
  parameter int BAUD_RATE  = 115_200,
  parameter int CLOCK_RATE = 200_000_000
) (
  input  logic     clk_tx,
  input  logic     rst_clk_tx,
  uart_tx_if.slave tx,
  output logic     txd_o,
  output logic     tx_busy
);
  localparam int BIT_DIV = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CW = $clog2(BIT_DIV);
  if (BIT_DIV < 2) begin : g_div_check
    $error("uart_tx: BIT_DIV must be at least 2");
  end
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift, hold_data;
  logic          hold_full, load, bit_end, txd_nx, busy_nx;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif
  assign tx.tx_ready = !hold_full;
  assign bit_end = cnt == CW'(BIT_DIV - 1);
  // Every state other than IDLE is left only at a bit end, so clearing there covers state entry.
  always_ff @(posedge clk_tx) begin
    if (rst_clk_tx) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      txd_o     <= 1'b1;
      tx_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      cnt       <= bit_end || state == IDLE ? '0 : cnt + 1'b1;
      idx       <= state != DATA ? '0 : bit_end ? idx + 3'd1 : idx;
      shift     <= load ? hold_data : state == DATA && bit_end ? shift >> 1 : shift;
      hold_full <= !load && (hold_full || tx.tx_valid);
      hold_data <= tx.tx_valid && !hold_full ? tx.tx_data : hold_data;
      txd_o     <= txd_nx;
      tx_busy   <= busy_nx;
`ifdef UART_TX_PARITY_EN
      par       <= load ? ^hold_data : par;
`endif
    end
  end
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        state_nx = hold_full ? START : IDLE;
        load     = hold_full;
      end
      START: state_nx = bit_end ? DATA : START;
      DATA: if (bit_end && idx == 3'd7)
`ifdef UART_TX_PARITY_EN
        state_nx = PARITY;
      PARITY: state_nx = bit_end ? STOP : PARITY;
`else
        state_nx = STOP;
`endif
      STOP: if (bit_end) begin
        state_nx = hold_full ? START : IDLE;
        load     = hold_full;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    txd_nx = state == START ? 1'b0 : state == DATA ? shift[0] :
`ifdef UART_TX_PARITY_EN
             state == PARITY ? par :
`endif
             1'b1;
    busy_nx = state != IDLE || hold_full;
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven cycle-exact frame checks plus a txd_o decoder that
// pops the expected-byte queue filled at each handshake.
module tb_uart_tx;
  localparam int BIT_DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       txd_o, tx_busy;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         hs_cyc = 0;
  logic [7:0] exp_q[$];
  vec_t       vec[5];
  uart_tx_if bus();
  uart_tx #(.BAUD_RATE(100_000), .CLOCK_RATE(1_600_000)) dut (
    .clk_tx(clk), .rst_clk_tx(rst), .tx(bus), .txd_o(txd_o), .tx_busy(tx_busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  function automatic logic [31:0] frame_bits(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {21'd0, 1'b1, ^d, d, 1'b0};
`else
    return {22'd0, 1'b1, d, 1'b0};
`endif
  endfunction
  task automatic push_byte(input logic [7:0] d);
    int w = 0;
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    while (bus.tx_ready !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) begin
      chk("push_timeout", 1'b0, 1'b1);
      bus.tx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    exp_q.push_back(d);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
  endtask
  task automatic check_cells(input string name, input logic [31:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      logic got;
      got = bits[k];
      for (int j = 0; j < BIT_DIV; j++) begin
        @(negedge clk);
        if (txd_o !== bits[k]) got = txd_o;
      end
      chk($sformatf("%s_cell%0d", name, k), got, bits[k]);
    end
  endtask
  task automatic wait_idle();
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((tx_busy !== 1'b0 || txd_o !== 1'b1) && w < 2000);
    if (w >= 2000) chk("idle_timeout", tx_busy, 1'b0);
  endtask
  // Independent receiver: samples each bit at mid-cell and scoreboards the byte.
  initial begin
    logic       act;
    int         c;
    logic [10:0] b;
    logic [7:0] e;
    act = 1'b0;
    c = 0;
    b = '0;
    forever begin
      @(negedge clk);
      if (rst) act = 1'b0;
      else if (!act) begin
        if (txd_o === 1'b0) begin
          act = 1'b1;
          c = 0;
        end
      end else begin
        c++;
        if (c >= 8 && (c - 8) % BIT_DIV == 0) begin
          b[(c-8)/BIT_DIV] = txd_o;
          if ((c - 8) / BIT_DIV == NB - 1) begin
            act = 1'b0;
            chk("mon_start", b[0], 1'b0);
            chk("mon_stop", b[NB-1], 1'b1);
`ifdef UART_TX_PARITY_EN
            chk("mon_parity", b[9], ^b[8:1]);
`endif
            if (exp_q.size() == 0) chk("mon_unexpected", 1'b1, 1'b0);
            else begin
              e = exp_q.pop_front();
              chk("mon_byte", b[8:1], e);
            end
          end
        end
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
  initial begin
    logic [31:0] bits;
    logic        bad;
    int          n1, ha, hb;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    vec[0] = '{8'hA5, 1'b0};
    vec[1] = '{8'h3C, 1'b0};
    vec[2] = '{8'h07, 1'b1};
    vec[3] = '{8'h03, 1'b0};
    vec[4] = '{8'h80, 1'b1};
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (txd_o !== 1'b1 || bus.tx_ready !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
    end
    chk("reset_hold", bad, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_txd", txd_o, 1'b1);
    chk("reset_ready", bus.tx_ready, 1'b1);
    chk("reset_busy", tx_busy, 1'b0);
    for (int i = 0; i < 5; i++) begin
`ifdef UART_TX_PARITY_EN
      bits = {21'd0, 1'b1, vec[i].par, vec[i].data, 1'b0};
`else
      bits = {22'd0, 1'b1, vec[i].data, 1'b0};
`endif
      push_byte(vec[i].data);
      @(negedge clk);
      chk($sformatf("v%0d_ready_held", i), bus.tx_ready, 1'b0);
      chk($sformatf("v%0d_busy_early", i), tx_busy, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_txd_pre", i), txd_o, 1'b1);
      chk($sformatf("v%0d_ready_back", i), bus.tx_ready, 1'b1);
      check_cells($sformatf("v%0d", i), bits, NB);
      chk($sformatf("v%0d_busy_last", i), tx_busy, 1'b1);
      @(negedge clk);
      chk($sformatf("v%0d_busy_drop", i), tx_busy, 1'b0);
      chk($sformatf("v%0d_txd_idle", i), txd_o, 1'b1);
    end
    push_byte(8'h00);
    n1 = hs_cyc;
    @(negedge clk);
    @(negedge clk);
    fork
      check_cells("b2b", (frame_bits(8'hFF) << NB) | frame_bits(8'h00), 2 * NB);
      begin
        logic rb;
        rb = 1'b0;
        repeat (18) @(negedge clk);
        push_byte(8'hFF);
        while (cyc < n1 + 161) begin
          @(negedge clk);
          if (cyc < n1 + 161 && bus.tx_ready !== 1'b0) rb = 1'b1;
        end
        chk("b2b_ready_low", rb, 1'b0);
        chk("b2b_ready_back", bus.tx_ready, 1'b1);
      end
    join
    wait_idle();
    push_byte(8'h12);
    ha = hs_cyc;
    push_byte(8'h36);
    hb = hs_cyc;
    push_byte(8'h3C);
    chk("bp_second_accept", hb - ha, 2);
    chk("bp_third_accept", hs_cyc - ha, 162);
    wait_idle();
    chk("bp_drained", exp_q.size(), 0);
    push_byte(8'h55);
    n1 = hs_cyc;
    push_byte(8'h99);
    while (cyc < n1 + 2 + 4 * BIT_DIV + 8) @(negedge clk);
    chk("pre_rst_d3", txd_o, 1'b0);
    chk("pre_rst_held", bus.tx_ready, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_txd", txd_o, 1'b1);
    chk("rst_ready", bus.tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    bad = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (txd_o !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
    end
    chk("rst_no_resend", bad, 1'b0);
    push_byte(8'hC3);
    @(negedge clk);
    @(negedge clk);
    check_cells("post_rst", frame_bits(8'hC3), NB);
    wait_idle();
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
